// File: rtl/item_fifo_if.sv
// Handshake bundle for item_fifo: upstream push channel and downstream pop channel.
// The producer/consumer side takes the master modport; the FIFO takes the slave modport.
interface item_fifo_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] in_item;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_item;
  logic             out_ready;

  modport master (
    output in_valid, in_item, out_ready,
    input  in_ready, out_valid, out_item
  );

  modport slave (
    input  in_valid, in_item, out_ready,
    output in_ready, out_valid, out_item
  );
endinterface

// File: rtl/item_fifo.sv
// Synchronous FIFO with a registered occupancy count, sticky overflow flag and a
// saturating counter of rejected push attempts.
module item_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  item_fifo_if.slave    bus,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic [7:0]       drop_cnt_r;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             reject_s;

  // Handshake qualifiers; ready/valid come only from the registered count.
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    empty_s  = (count_r == {CW{1'b0}});
    push_s   = bus.in_valid && !full_s;
    pop_s    = bus.out_ready && !empty_s;
    reject_s = bus.in_valid && full_s;
  end

  assign bus.in_ready  = !full_s;
  assign bus.out_valid = !empty_s;
  assign bus.out_item  = mem_r[rd_ptr_r];
  assign count         = count_r;
  assign overflow      = overflow_r;
  assign drop_cnt      = drop_cnt_r;

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= bus.in_item;
    end
  end

  // Pointers, occupancy and error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (reject_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'd255) begin
          drop_cnt_r <= drop_cnt_r + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/item_fifo.md
ITEM_FIFO -- requirements
Module: item_fifo

Interface
- REQ-001: Parameter WIDTH, default 3, item width in bits; matches the interface item field.
- REQ-002: Parameter DEPTH, default 4, storage entries; power of two, 2..16.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: in_valid  input  1  upstream item present.
- REQ-006: in_item  input  WIDTH  upstream item.
- REQ-007: in_ready  output  1  FIFO can accept; equals (count != DEPTH).
- REQ-008: out_valid  output  1  head item present; equals (count != 0).
- REQ-009: out_item  output  WIDTH  head item; value is don't-care when out_valid=0.
- REQ-010: out_ready  input  1  downstream (interface consumer) accepts head.
- REQ-011: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- REQ-012: overflow  output  1  sticky: set when in_valid=1 while in_ready=0.
- REQ-013: drop_cnt  output  8  number of cycles with in_valid=1 and in_ready=0; saturates at 255.

Function
- REQ-014: Push occurs in a cycle iff in_valid && in_ready; item written at wr_ptr, wr_ptr increments mod DEPTH.
- REQ-015: Pop occurs in a cycle iff out_valid && out_ready; rd_ptr increments mod DEPTH.
- REQ-016: Push only: count+1; pop only: count-1; both or neither: count unchanged.
- REQ-017: Simultaneous push and pop when full is impossible (in_ready=0); when empty, only push occurs (no fall-through); the pushed item is visible on out_item the next cycle.
- REQ-018: Latency: item pushed in cycle N is presentable at out_item no earlier than cycle N+1.
- REQ-019: Ordering is strict FIFO; pointer wrap-around from DEPTH-1 to 0 preserves order.
- REQ-020: in_ready and out_valid depend only on registered count; no combinational path from out_ready to in_ready or from in_valid to out_valid.
- REQ-021: Rejected item (in_valid && !in_ready) does not alter storage, pointers or count.
- REQ-022: overflow is set on the cycle after a rejection and stays 1 until reset.
- REQ-023: drop_cnt increments by 1 per rejecting cycle and holds at 255 once reached.
- REQ-024: out_item is stable while out_valid=1 and out_ready=0.

Reset
- REQ-025: While rst=1 at a rising edge: count=0, wr_ptr=0, rd_ptr=0, overflow=0, drop_cnt=0; thus out_valid=0, in_ready=1 the following cycle.
- REQ-026: Reset mid-operation discards all stored items; storage array contents need not be cleared.
- REQ-027: rst takes priority over simultaneous push/pop in the same cycle.

Verification
- REQ-028: Reset, then push 3'd1,3'd2,3'd3 with out_ready=0 -> count=3, out_item=3'd1, in_ready=1.
- REQ-029: Push 4 items (DEPTH=4) with out_ready=0, then a 5th item 3'd7 -> in_ready=0, count=4, overflow=1 next cycle, drop_cnt=1, 3'd7 never appears at output.
- REQ-030: Full FIFO, assert in_valid and out_ready together for one cycle -> one pop only, count=3; next cycle push accepted, count=4.
- REQ-031: Stream 10 items 0..7,0,1 with in_valid=1 and out_ready=1 continuously -> output order identical, count never exceeds 1, pointers wrap without loss.
- REQ-032: Hold in_valid=1 on a full FIFO for 300 cycles -> drop_cnt=255 (saturated), overflow=1.
- REQ-033: Assert rst with count=2 and overflow=1 -> next cycle count=0, out_valid=0, overflow=0, drop_cnt=0.
